// File: rtl/quick_spi_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// quick_spi_cmd_sequencer - FIFO-buffered command sequencer for quick_spi.
// Revision 1.0 - initial release
// ============================================================================
module quick_spi_cmd_sequencer #(
   parameter int OUT_WIDTH  = 16,
   parameter int IN_WIDTH   = 8,
   parameter int SLAVES     = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 1024
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_operation,
   input  logic [SLAVES-1:0]    cmd_slave,
   input  logic [OUT_WIDTH-1:0] cmd_data,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IN_WIDTH-1:0]  rsp_data,
   output logic                 rsp_error,
   output logic                 spi_enable,
   output logic                 spi_start_transaction,
   output logic                 spi_operation,
   output logic [SLAVES-1:0]    spi_slave,
   output logic [OUT_WIDTH-1:0] spi_outgoing_data,
   input  logic                 spi_end_of_transaction,
   input  logic [IN_WIDTH-1:0]  spi_incoming_data
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = $clog2(TIMEOUT + 1);
   localparam int ENTRY_W = 1 + SLAVES + OUT_WIDTH;
   localparam logic [PTR_W:0]   C_FULL     = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_RESPOND = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]       count_q, count_d;
   logic                 cmd_ready_q, cmd_ready_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [IN_WIDTH-1:0]  rsp_data_q, rsp_data_d;
   logic                 rsp_error_q, rsp_error_d;
   logic                 enable_q, enable_d;
   logic                 start_q, start_d;
   logic                 op_q, op_d;
   logic [SLAVES-1:0]    slave_q, slave_d;
   logic [OUT_WIDTH-1:0] out_q, out_d;
   logic [CNT_W-1:0]     tmo_q, tmo_d;
   logic                 push, pop;

   always_comb begin
      push        = cmd_valid && cmd_ready_q;
      pop         = (state_q == ST_IDLE) && (count_q != '0) && !rsp_valid_q;
      state_d     = state_q;
      wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d     = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
      cmd_ready_d = (count_d != C_FULL);
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_error_d = rsp_error_q;
      enable_d    = 1'b1;
      start_d     = 1'b0;
      op_d        = op_q;
      slave_d     = slave_q;
      out_d       = out_q;
      tmo_d       = tmo_q;
      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               {op_d, slave_d, out_d} = mem_q[rd_ptr_q];
               start_d                = 1'b1;
               state_d                = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            tmo_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A completion landing on the last allowed cycle beats the timeout.
            if (spi_end_of_transaction) begin
               rsp_data_d  = op_q ? spi_incoming_data : '0;
               rsp_error_d = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESPOND;
            end else if (tmo_q == C_TMO_LAST) begin
               rsp_data_d  = '0;
               rsp_error_d = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESPOND;
            end else begin
               tmo_d = tmo_q + CNT_W'(1);
            end
         end
         ST_RESPOND: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               slave_d     = '0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_error_q <= 1'b0;
         enable_q    <= 1'b0;
         start_q     <= 1'b0;
         op_q        <= 1'b0;
         slave_q     <= '0;
         out_q       <= '0;
         tmo_q       <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_error_q <= rsp_error_d;
         enable_q    <= enable_d;
         start_q     <= start_d;
         op_q        <= op_d;
         slave_q     <= slave_d;
         out_q       <= out_d;
         tmo_q       <= tmo_d;
      end
   end

   // Storage needs no reset: entries are only read when the count says valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {cmd_operation, cmd_slave, cmd_data};
      end
   end

   assign cmd_ready             = cmd_ready_q;
   assign rsp_valid             = rsp_valid_q;
   assign rsp_data              = rsp_data_q;
   assign rsp_error             = rsp_error_q;
   assign spi_enable            = enable_q;
   assign spi_start_transaction = start_q;
   assign spi_operation         = op_q;
   assign spi_slave             = slave_q;
   assign spi_outgoing_data     = out_q;

endmodule
`default_nettype wire

// File: tb/tb_quick_spi_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// tb_quick_spi_cmd_sequencer - directed bench for the quick_spi command sequencer.
// Revision 1.0 - initial release
// ============================================================================
module tb_quick_spi_cmd_sequencer;

   localparam int TMO = 64;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid, cmd_ready, cmd_operation;
   logic [1:0]  cmd_slave;
   logic [15:0] cmd_data;
   logic        rsp_valid, rsp_ready, rsp_error;
   logic [7:0]  rsp_data;
   logic        spi_enable, spi_start_transaction, spi_operation;
   logic [1:0]  spi_slave;
   logic [15:0] spi_outgoing_data;
   logic        spi_end_of_transaction;
   logic [7:0]  spi_incoming_data;

   quick_spi_cmd_sequencer #(
      .OUT_WIDTH (16),
      .IN_WIDTH  (8),
      .SLAVES    (2),
      .FIFO_DEPTH(4),
      .TIMEOUT   (TMO)
   ) dut (
      .clk                   (clk),
      .reset_n               (reset_n),
      .cmd_valid             (cmd_valid),
      .cmd_ready             (cmd_ready),
      .cmd_operation         (cmd_operation),
      .cmd_slave             (cmd_slave),
      .cmd_data              (cmd_data),
      .rsp_valid             (rsp_valid),
      .rsp_ready             (rsp_ready),
      .rsp_data              (rsp_data),
      .rsp_error             (rsp_error),
      .spi_enable            (spi_enable),
      .spi_start_transaction (spi_start_transaction),
      .spi_operation         (spi_operation),
      .spi_slave             (spi_slave),
      .spi_outgoing_data     (spi_outgoing_data),
      .spi_end_of_transaction(spi_end_of_transaction),
      .spi_incoming_data     (spi_incoming_data)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        op;
      logic [1:0]  slave;
      logic [15:0] data;
      int          delay;     // WAIT cycles before end pulse; 0 = never ends
      logic [7:0]  din;
      logic [7:0]  exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push_one();
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_start(input string nm);
      int c = 0;
      while (!spi_start_transaction && c < 20) begin
         @(negedge clk);
         c++;
      end
      check(nm, {31'd0, spi_start_transaction}, 32'd1);
   endtask

   // Called in a WAIT cycle: pulse completion, check and accept the response.
   task automatic complete(input logic [7:0] din, input string nm);
      spi_end_of_transaction = 1'b1;
      spi_incoming_data      = din;
      @(negedge clk);
      spi_end_of_transaction = 1'b0;
      check({nm, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({nm, " rsp_data"}, {24'd0, rsp_data}, {24'd0, din});
      check({nm, " rsp_error"}, {31'd0, rsp_error}, 32'd0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic serve(input logic [15:0] exp_out, input logic [7:0] din, input string nm);
      wait_start({nm, " start"});
      check({nm, " out"}, {16'd0, spi_outgoing_data}, {16'd0, exp_out});
      @(negedge clk);
      complete(din, nm);
   endtask

   task automatic run_vec(input vec_t v, input int i);
      string nm;
      int    c;
      logic  held;
      nm = $sformatf("vec%0d", i);
      cmd_operation = v.op;
      cmd_slave     = v.slave;
      cmd_data      = v.data;
      push_one();
      check({nm, " start_early"}, {31'd0, spi_start_transaction}, 32'd0);
      @(negedge clk);
      check({nm, " start"}, {31'd0, spi_start_transaction}, 32'd1);
      check({nm, " op"}, {31'd0, spi_operation}, {31'd0, v.op});
      check({nm, " slave"}, {30'd0, spi_slave}, {30'd0, v.slave});
      check({nm, " out"}, {16'd0, spi_outgoing_data}, {16'd0, v.data});
      @(negedge clk);
      check({nm, " start_once"}, {31'd0, spi_start_transaction}, 32'd0);
      if (v.delay > 0) begin
         held = 1'b1;
         for (int k = 1; k < v.delay; k++) begin
            if (spi_slave !== v.slave || spi_outgoing_data !== v.data ||
                spi_start_transaction !== 1'b0 || rsp_valid !== 1'b0) held = 1'b0;
            @(negedge clk);
         end
         check({nm, " held"}, {31'd0, held}, 32'd1);
         spi_end_of_transaction = 1'b1;
         spi_incoming_data      = v.din;
         @(negedge clk);
         spi_end_of_transaction = 1'b0;
      end else begin
         c = 0;
         while (!rsp_valid && c < TMO + 8) begin
            @(negedge clk);
            c++;
         end
         check({nm, " timeout_cycles"}, c, TMO);
      end
      check({nm, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({nm, " rsp_data"}, {24'd0, rsp_data}, {24'd0, v.exp_data});
      check({nm, " rsp_error"}, {31'd0, rsp_error}, {31'd0, v.exp_err});
      @(negedge clk);
      check({nm, " rsp_hold"}, {23'd0, rsp_valid, rsp_data}, {23'd0, 1'b1, v.exp_data});
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check({nm, " rsp_done"}, {31'd0, rsp_valid}, 32'd0);
      check({nm, " slave_idle"}, {30'd0, spi_slave}, 32'd0);
   endtask

   logic [15:0] qv[5];
   int          n_acc, c, starts;
   logic        acc, quiet;

   initial begin
      vecs[0] = '{1'b0, 2'b01, 16'h5A6A, 40,  8'h33, 8'h00, 1'b0};
      vecs[1] = '{1'b1, 2'b10, 16'h1234, 5,   8'hA9, 8'hA9, 1'b0};
      vecs[2] = '{1'b1, 2'b01, 16'hFFFF, 1,   8'h5C, 8'h5C, 1'b0};
      vecs[3] = '{1'b1, 2'b10, 16'h0000, TMO, 8'h3C, 8'h3C, 1'b0};
      vecs[4] = '{1'b1, 2'b01, 16'hBEEF, 0,   8'h77, 8'h00, 1'b1};
      vecs[5] = '{1'b0, 2'b10, 16'h8001, 0,   8'h00, 8'h00, 1'b1};
      qv      = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};

      reset_n = 1'b0;
      cmd_valid = 1'b0; cmd_operation = 1'b0; cmd_slave = '0; cmd_data = '0;
      rsp_ready = 1'b0; spi_end_of_transaction = 1'b0; spi_incoming_data = '0;
      repeat (3) @(negedge clk);
      check("reset outputs",
            {24'd0, cmd_ready, rsp_valid, rsp_error, spi_enable,
             spi_start_transaction, spi_operation, spi_slave}, 32'd0);
      check("reset data", {8'd0, rsp_data, spi_outgoing_data}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("post reset ready/enable", {30'd0, cmd_ready, spi_enable}, 32'd3);

      foreach (vecs[i]) run_vec(vecs[i], i);

      // FIFO fill while one transaction is outstanding
      cmd_operation = 1'b1; cmd_slave = 2'b01; cmd_data = 16'h0F00;
      push_one();
      wait_start("q0 start");
      @(negedge clk);
      n_acc = 0;
      cmd_valid = 1'b1;
      cmd_data  = qv[0];
      for (int k = 0; k < 6; k++) begin
         acc = cmd_ready;
         @(negedge clk);
         if (acc) begin
            n_acc++;
            if (n_acc < 5) cmd_data = qv[n_acc];
         end
      end
      check("fifo accepts", n_acc, 4);
      check("fifo full ready", {31'd0, cmd_ready}, 32'd0);
      complete(8'h10, "q0");
      c = 0;
      while (!cmd_ready && c < 10) begin
         @(negedge clk);
         c++;
      end
      check("fifo ready again", {31'd0, cmd_ready}, 32'd1);
      check("q1 start", {31'd0, spi_start_transaction}, 32'd1);
      check("q1 out", {16'd0, spi_outgoing_data}, {16'd0, qv[0]});
      @(negedge clk);
      cmd_valid = 1'b0;
      complete(8'h21, "q1");
      for (int k = 1; k < 5; k++)
         serve(qv[k], 8'h21 + 8'(k), $sformatf("q%0d", k + 1));

      // Pending response blocks further starts
      cmd_data = 16'hC000;
      push_one();
      wait_start("blk start");
      @(negedge clk);
      spi_end_of_transaction = 1'b1;
      spi_incoming_data = 8'h44;
      @(negedge clk);
      spi_end_of_transaction = 1'b0;
      cmd_data = 16'hC001; push_one();
      cmd_data = 16'hC002; push_one();
      starts = 0;
      for (int k = 0; k < 20; k++) begin
         if (spi_start_transaction) starts++;
         @(negedge clk);
      end
      check("blocked starts", starts, 0);
      check("blocked rsp", {23'd0, rsp_valid, rsp_data}, {23'd0, 1'b1, 8'h44});
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      serve(16'hC001, 8'h51, "blk1");
      serve(16'hC002, 8'h52, "blk2");

      // End pulse while idle is ignored
      spi_end_of_transaction = 1'b1;
      spi_incoming_data = 8'hEE;
      @(negedge clk);
      spi_end_of_transaction = 1'b0;
      quiet = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (rsp_valid || spi_start_transaction) quiet = 1'b0;
         @(negedge clk);
      end
      check("idle end ignored", {31'd0, quiet}, 32'd1);

      // Reset in the middle of WAIT with a second command queued
      cmd_operation = 1'b1; cmd_slave = 2'b10; cmd_data = 16'hD00D;
      push_one();
      wait_start("rst start");
      cmd_data = 16'hD00E;
      push_one();
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("rst async outputs",
            {24'd0, cmd_ready, rsp_valid, rsp_error, spi_enable,
             spi_start_transaction, spi_operation, spi_slave}, 32'd0);
      check("rst async data", {8'd0, rsp_data, spi_outgoing_data}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      quiet = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (rsp_valid || spi_start_transaction) quiet = 1'b0;
      end
      check("rst aborted/discarded", {31'd0, quiet}, 32'd1);
      check("rst ready again", {31'd0, cmd_ready}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1);
   end

endmodule
`default_nettype wire
